// File: rtl/input_event_decoder_pkg.sv
// Shared types for the switch/button input event decoder: event kinds,
// source count and the FIFO entry layout.
package input_evt_pkg;

    typedef enum logic [1:0] {
        SW_ON  = 2'd0,
        SW_OFF = 2'd1,
        BTN_C  = 2'd2,
        BTN_R  = 2'd3
    } evt_kind_t;

    localparam int unsigned N_SRC     = 18;
    localparam int unsigned SRC_BTN_C = 0;
    localparam int unsigned SRC_BTN_R = 1;

    typedef struct packed {
        evt_kind_t  kind;
        logic [3:0] idx;
    } evt_entry_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        logic       found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i] && !found) begin
                r     = 4'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/input_event_decoder_if.sv
// Valid/ready event stream carrying one decoded input event per transfer.
interface input_event_decoder_if;
    import input_evt_pkg::*;

    logic       evt_valid;
    logic       evt_ready;
    evt_kind_t  evt_kind;
    logic [3:0] evt_idx;

    modport master (output evt_valid, output evt_kind, output evt_idx, input evt_ready);
    modport slave  (input evt_valid, input evt_kind, input evt_idx, output evt_ready);

endinterface

// File: rtl/input_event_decoder_debounce.sv
// One input source: 2-FF synchroniser followed by a tick-sampled debounce
// counter that only moves the stable level after STABLE_TICKS differing ticks.
module debounce_cell #(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic stable
);

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            if (tick) begin
                if (sync_q2 == stable) begin
                    cnt <= '0;
                end else if (cnt == 4'(STABLE_TICKS - 1)) begin
                    stable <= sync_q2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/input_event_decoder.sv
// Debounces 16 switches and two buttons, turns each stable change into an
// event, and queues events in a small FIFO behind a valid/ready port.
module input_event_decoder
    import input_evt_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 250000,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  sw,
    input  logic                         btnC,
    input  logic                         btnR,
    input_event_decoder_if.master        evt,
    output logic [15:0]                  sw_stable,
    output logic                         any_sw,
    output logic [3:0]                   top_idx
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [N_SRC-1:0] src_raw;
    logic [N_SRC-1:0] src_stable;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] chg;
    logic [N_SRC-1:0] set;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pend;
    logic             sel_valid;
    logic [4:0]       sel_src;
    logic [3:0]       sel_sw;
    evt_entry_t       push_entry;
    logic             push;
    logic             pop;
    evt_entry_t       mem [FIFO_DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;

    assign tick = (tick_cnt == TW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign src_raw = {sw, btnR, btnC};

    for (genvar g = 0; g < N_SRC; g++) begin : g_db
        debounce_cell #(.STABLE_TICKS(STABLE_TICKS)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .din    (src_raw[g]),
            .stable (src_stable[g])
        );
    end

    assign sw_stable = src_stable[N_SRC-1:2];

    // Buttons report presses only; switches report both directions.
    always_comb begin
        chg            = src_stable ^ src_prev;
        set            = chg;
        set[SRC_BTN_C] = chg[SRC_BTN_C] & src_stable[SRC_BTN_C];
        set[SRC_BTN_R] = chg[SRC_BTN_R] & src_stable[SRC_BTN_R];
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_src   = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (pend[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_src   = 5'(i);
            end
        end
        sel_sw     = 4'(sel_src - 5'd2);
        push_entry = '0;
        if (sel_src == 5'(SRC_BTN_C)) begin
            push_entry.kind = BTN_C;
        end else if (sel_src == 5'(SRC_BTN_R)) begin
            push_entry.kind = BTN_R;
        end else begin
            push_entry.kind = sw_stable[sel_sw] ? SW_ON : SW_OFF;
            push_entry.idx  = sel_sw;
        end
    end

    assign pop  = evt.evt_valid && evt.evt_ready;
    assign push = sel_valid && ((count < CW'(FIFO_DEPTH)) || pop);
    assign clr  = push ? (N_SRC'(1) << sel_src) : '0;

    // Clear wins over a same-cycle change: the pushed kind already carries the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev <= '0;
            pend     <= '0;
            any_sw   <= 1'b0;
            top_idx  <= '0;
        end else begin
            src_prev <= src_stable;
            pend     <= (pend | set) & ~clr;
            any_sw   <= |sw_stable;
            top_idx  <= lowest_set(sw_stable);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_entry;
                wptr      <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign evt.evt_valid = (count != '0);
    assign evt.evt_kind  = mem[rptr].kind;
    assign evt.evt_idx   = mem[rptr].idx;

endmodule

// File: tb/tb_input_event_decoder.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor
// pops and compares every accepted transfer.
module tb_input_event_decoder;
    import input_evt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic        btnC;
    logic        btnR;
    logic [15:0] sw_stable;
    logic        any_sw;
    logic [3:0]  top_idx;

    input_event_decoder_if evt_if ();

    input_event_decoder #(
        .TICK_CYCLES  (4),
        .STABLE_TICKS (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btnC      (btnC),
        .btnR      (btnR),
        .evt       (evt_if),
        .sw_stable (sw_stable),
        .any_sw    (any_sw),
        .top_idx   (top_idx)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    evt_entry_t exp_q[$];
    int         pop_cyc[$];
    evt_entry_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input evt_kind_t k, input logic [3:0] i);
        evt_entry_t e;
        e.kind = k;
        e.idx  = i;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check({"drain_", name}, exp_q.size(), 0);
        cycles(40);
    endtask

    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d idx %0d expected none",
                         evt_if.evt_kind, evt_if.evt_idx);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_kind", evt_if.evt_kind, mon_e.kind);
                check("evt_idx", evt_if.evt_idx, mon_e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        sw               = 16'h0021;
        btnC             = 1'b0;
        btnR             = 1'b0;
        evt_if.evt_ready = 1'b1;
        cycles(3);
        check("rst_valid", evt_if.evt_valid, 0);
        check("rst_kind", evt_if.evt_kind, 0);
        check("rst_idx", evt_if.evt_idx, 0);
        check("rst_sw_stable", sw_stable, 0);
        check("rst_any_sw", any_sw, 0);
        check("rst_top_idx", top_idx, 0);

        // switches held through reset release
        expect_evt(SW_ON, 4'd0);
        expect_evt(SW_ON, 4'd5);
        rst_n = 1'b1;
        drain("reset_exit", 80);
        check("exit_sw_stable", sw_stable, 16'h0021);
        check("exit_top_idx", top_idx, 0);
        check("exit_any_sw", any_sw, 1);

        // glitch rejection, then a real press
        sw = 16'h0029;
        cycles(10);
        sw = 16'h0021;
        cycles(40);
        check("glitch_sw_stable", sw_stable, 16'h0021);
        expect_evt(SW_ON, 4'd3);
        sw = 16'h0029;
        drain("sw3_on", 80);
        check("sw3_sw_stable", sw_stable, 16'h0029);

        // simultaneous edges
        pop_cyc.delete();
        expect_evt(BTN_R, 4'd0);
        expect_evt(SW_ON, 4'd2);
        expect_evt(SW_ON, 4'd7);
        btnR = 1'b1;
        sw   = 16'h00AD;
        drain("simul", 80);
        check("simul_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("simul_b2b_1", pop_cyc[1] - pop_cyc[0], 1);
            check("simul_b2b_2", pop_cyc[2] - pop_cyc[1], 1);
        end
        check("simul_sw_stable", sw_stable, 16'h00AD);

        // button press/release: releases are silent
        btnR = 1'b0;
        expect_evt(BTN_C, 4'd0);
        btnC = 1'b1;
        cycles(40);
        btnC = 1'b0;
        drain("btnc", 80);

        // backpressure: 6 events, 4 queued + 2 pending
        evt_if.evt_ready = 1'b0;
        for (int i = 10; i < 16; i++) expect_evt(SW_ON, 4'(i));
        sw = 16'hFCAD;
        cycles(50);
        check("bp_valid", evt_if.evt_valid, 1);
        check("bp_head_kind", evt_if.evt_kind, SW_ON);
        check("bp_head_idx", evt_if.evt_idx, 10);
        check("bp_pending", $countones(dut.pend), 2);
        cycles(5);
        check("bp_hold_kind", evt_if.evt_kind, SW_ON);
        check("bp_hold_idx", evt_if.evt_idx, 10);
        evt_if.evt_ready = 1'b1;
        drain("backpressure", 80);

        // coalescing sw[9] on then off while the queue is full
        evt_if.evt_ready = 1'b0;
        for (int i = 10; i < 14; i++) expect_evt(SW_OFF, 4'(i));
        sw = 16'hC0AD;
        cycles(50);
        check("co_full_pending", $countones(dut.pend), 0);
        sw = 16'hC2AD;
        cycles(40);
        check("co_sw9_on", sw_stable[9], 1);
        check("co_sw9_pend_on", dut.pend[11], 1);
        sw = 16'hC0AD;
        cycles(40);
        check("co_sw9_off", sw_stable[9], 0);
        check("co_sw9_pend_off", $countones(dut.pend), 1);
        expect_evt(SW_OFF, 4'd9);
        evt_if.evt_ready = 1'b1;
        drain("coalesce", 80);

        // async reset with 3 events queued
        evt_if.evt_ready = 1'b0;
        sw = 16'h00AC;
        cycles(50);
        check("mq_valid", evt_if.evt_valid, 1);
        check("mq_count", dut.count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mq_async_valid", evt_if.evt_valid, 0);
        exp_q.delete();
        sw = 16'h0000;
        cycles(3);
        rst_n            = 1'b1;
        evt_if.evt_ready = 1'b1;
        cycles(80);
        check("mq_post_valid", evt_if.evt_valid, 0);
        check("mq_post_sw_stable", sw_stable, 0);
        check("mq_post_any_sw", any_sw, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
